// File: rtl/csel_pkg.sv
// Shared parameters, per-stage control record and sizing helper for the
// pipelined carry-select adder.
package csel_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_BLK   = 8;

  // Per-stage control: beat valid plus the resolved carry out of this block.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int nblk(input int width, input int blk);
    return (blk > 0) ? width / blk : 1;
  endfunction

endpackage

// File: rtl/csel_block.sv
// One carry-select slice: both candidate sums are formed in parallel and the
// incoming carry only drives the final mux.
module csel_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a_blk,
  input  logic [BLK-1:0] b_blk,
  input  logic           csel,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0] s0;
  logic [BLK:0] s1;

  always_comb begin
    s0      = {1'b0, a_blk} + {1'b0, b_blk};
    s1      = {1'b0, a_blk} + {1'b0, b_blk} + {{BLK{1'b0}}, 1'b1};
    {co, s} = csel ? s1 : s0;
  end

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor, one stage per BLK-bit block.
// Define CSEL_OVF_FLAG_EN to add the registered signed-overflow output ovf.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLK   = DEFAULT_BLK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CSEL_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = nblk(WIDTH, BLK);

  if (BLK < 1 || (WIDTH % BLK) != 0) begin : g_param_check
    $error("pipelined_csel_adder: WIDTH (%0d) must be a positive multiple of BLK (%0d)",
           WIDTH, BLK);
  end

  logic             adv;
  logic             cin_eff;
  logic [WIDTH-1:0] b_eff;

  // The whole pipeline moves together; bubbles keep their slot.
  always_comb begin
    adv     = !out_valid || out_ready;
    cin_eff = sub | cin;
    b_eff   = sub ? ~b : b;
  end

  assign in_ready = adv;

  // Stage k owns the finished sum slices 0..k, the real carry out of block k
  // and the not-yet-added operand slices k+1..NBLK-1 (right-aligned).
  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    localparam int SW = (k + 1) * BLK;

    logic [BLK-1:0] a_blk;
    logic [BLK-1:0] b_blk;
    logic [BLK-1:0] s_blk;
    logic           c_in;
    logic           v_in;
    logic           co;
    logic [SW-1:0]  sum_d;
    logic [SW-1:0]  sum_q;
    stage_ctl_t     ctl_d;
    stage_ctl_t     ctl_q;

    if (k == 0) begin : g_src
      // NOTE: every variable written in always_comb is assigned on every path,
      // otherwise synthesis infers a latch to hold the old value.
      always_comb begin
        a_blk = a[BLK-1:0];
        b_blk = b_eff[BLK-1:0];
        c_in  = cin_eff;
        v_in  = in_valid;
        sum_d = s_blk;
      end
    end else begin : g_src
      always_comb begin
        a_blk = g_stg[k-1].g_op.a_q[BLK-1:0];
        b_blk = g_stg[k-1].g_op.b_q[BLK-1:0];
        c_in  = g_stg[k-1].ctl_q.carry;
        v_in  = g_stg[k-1].ctl_q.valid;
        sum_d = {s_blk, g_stg[k-1].sum_q};
      end
    end

    csel_block #(.BLK(BLK)) u_blk (
      .a_blk (a_blk),
      .b_blk (b_blk),
      .csel  (c_in),
      .s     (s_blk),
      .co    (co)
    );

    always_comb begin
      ctl_d.valid = v_in;
      ctl_d.carry = co;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    // NOTE: datapath registers are reset too, so sum/cout read 0 after reset
    // instead of stale operands.
    always_ff @(posedge clk) begin
      if (rst) begin
        ctl_q <= '0;
        sum_q <= '0;
      end else if (adv) begin
        ctl_q <= ctl_d;
        sum_q <= sum_d;
      end
    end

    if (k < NBLK - 1) begin : g_op
      localparam int OW = WIDTH - SW;

      logic [OW-1:0] a_d;
      logic [OW-1:0] a_q;
      logic [OW-1:0] b_d;
      logic [OW-1:0] b_q;

      if (k == 0) begin : g_src
        always_comb begin
          a_d = a[WIDTH-1:BLK];
          b_d = b_eff[WIDTH-1:BLK];
        end
      end else begin : g_src
        always_comb begin
          a_d = g_stg[k-1].g_op.a_q[WIDTH-k*BLK-1:BLK];
          b_d = g_stg[k-1].g_op.b_q[WIDTH-k*BLK-1:BLK];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign out_valid = g_stg[NBLK-1].ctl_q.valid;
  assign cout      = g_stg[NBLK-1].ctl_q.carry;
  assign sum       = g_stg[NBLK-1].sum_q;

`ifdef CSEL_OVF_FLAG_EN
  logic ovf_d;
  logic ovf_q;

  // The top block's operands and result carry the sign bits.
  always_comb begin
    ovf_d = (g_stg[NBLK-1].a_blk[BLK-1] == g_stg[NBLK-1].b_blk[BLK-1]) &&
            (g_stg[NBLK-1].s_blk[BLK-1] != g_stg[NBLK-1].a_blk[BLK-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Self-checking bench: directed vectors on the 32/8 adder, then a random
// scoreboard run over 32/8, 24/6 and 16/16 instances driven in parallel.
module tb_pipelined_csel_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        cin;
  logic        sub;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;

  logic        ir0, ov0, co0;
  logic [31:0] s0;
  logic        ir1, ov1, co1;
  logic [23:0] s1;
  logic        ir2, ov2, co2;
  logic [15:0] s2;
`ifdef CSEL_OVF_FLAG_EN
  logic        of0, of1, of2;
`endif

  pipelined_csel_adder #(.WIDTH(32), .BLK(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .sum(s0), .cout(co0)
`ifdef CSEL_OVF_FLAG_EN
    , .ovf(of0)
`endif
  );

  pipelined_csel_adder #(.WIDTH(24), .BLK(6)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .a(a[23:0]), .b(b[23:0]), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1)
`ifdef CSEL_OVF_FLAG_EN
    , .ovf(of1)
`endif
  );

  pipelined_csel_adder #(.WIDTH(16), .BLK(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .sum(s2), .cout(co2)
`ifdef CSEL_OVF_FLAG_EN
    , .ovf(of2)
`endif
  );

  logic [31:0] sum_v [3];
  logic [2:0]  rdy_v, vld_v, co_v;
`ifdef CSEL_OVF_FLAG_EN
  logic [2:0]  of_v;
  assign of_v = {of2, of1, of0};
`endif

  always_comb begin
    sum_v[0] = s0;
    sum_v[1] = {8'h00, s1};
    sum_v[2] = {16'h0000, s2};
    rdy_v    = {ir2, ir1, ir0};
    vld_v    = {ov2, ov1, ov0};
    co_v     = {co2, co1, co0};
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full-precision reference: {ovf, cout, sum} for a w-bit adder.
  function automatic logic [33:0] model(input int w, input logic [31:0] ta,
                                        input logic [31:0] tb_, input logic tc,
                                        input logic ts);
    logic [63:0] mask, am, bm, full;
    logic [31:0] sm;
    logic        cy, of;
    mask = (64'd1 << w) - 64'd1;
    am   = {32'h0, ta} & mask;
    bm   = {32'h0, (ts ? ~tb_ : tb_)} & mask;
    full = am + bm + {63'h0, (ts | tc)};
    sm   = full[31:0] & mask[31:0];
    cy   = full[w];
    of   = (am[w-1] == bm[w-1]) && (full[w-1] != am[w-1]);
    return {of, cy, sm};
  endfunction

  function automatic int width_of(input int i);
    return (i == 0) ? 32 : (i == 1) ? 24 : 16;
  endfunction

  logic [33:0] sb [3][16];
  int          wr [3];
  int          rd [3];

  // Called at the falling edge: scores what the coming rising edge transfers.
  task automatic sb_step();
    logic [33:0] e;
    for (int i = 0; i < 3; i++) begin
      if (vld_v[i] && out_ready) begin
        if (wr[i] == rd[i]) begin
          check($sformatf("dut%0d spurious beat", i), vld_v[i], 1'b0);
        end else begin
          e = sb[i][rd[i] % 16];
          rd[i]++;
          check($sformatf("dut%0d sum beat %0d", i, rd[i]), sum_v[i], e[31:0]);
          check($sformatf("dut%0d cout beat %0d", i, rd[i]), co_v[i], e[32]);
`ifdef CSEL_OVF_FLAG_EN
          check($sformatf("dut%0d ovf beat %0d", i, rd[i]), of_v[i], e[33]);
`endif
        end
      end
      if (in_valid && rdy_v[i]) begin
        sb[i][wr[i] % 16] = model(width_of(i), a, b, cin, sub);
        wr[i]++;
      end
    end
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb_,
                       input logic tc, input logic ts);
    in_valid = 1'b1;
    a        = ta;
    b        = tb_;
    cin      = tc;
    sub      = ts;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single beat on the 32/8 instance with out_ready held high.
  task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                         input logic tc, input logic ts,
                         input logic [31:0] es, input logic ec);
    int lat;
    drive(ta, tb_, tc, ts);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!ov0 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " sum"}, s0, es);
    check({tag, " cout"}, co0, ec);
  endtask

  logic [32:0] stall_exp [3];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 0;
      rd[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("reset out_valid", ov0, 1'b0);
    check("reset sum", s0, 32'h0);
    check("reset cout", co0, 1'b0);
    check("reset in_ready", ir0, 1'b1);

    run_one("carry ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    run_one("sub borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    run_one("sub ignores cin", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1);
    run_one("add with cin", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0);
    run_one("block0 carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
`ifdef CSEL_OVF_FLAG_EN
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("ovf valid", ov0, 1'b1);
    check("ovf sum", s0, 32'h8000_0000);
    check("ovf flag", of0, 1'b1);
`endif
    idle(2);

    // Back-to-back beats must emerge on consecutive cycles, in order.
    drive(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    stall_exp[0] = {1'b0, 32'h0000_0030};
    stall_exp[1] = {1'b0, 32'h0100_0100};
    stall_exp[2] = {1'b1, 32'h0000_0000};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b valid %0d", i), ov0, 1'b1);
      check($sformatf("b2b sum %0d", i), s0, stall_exp[i][31:0]);
      check($sformatf("b2b cout %0d", i), co0, stall_exp[i][32]);
    end
    idle(2);

    // Backpressure: output frozen while out_ready is low, then clean drain.
    out_ready = 1'b0;
    drive(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    stall_exp[0] = {1'b0, 32'h0000_0003};
    stall_exp[1] = {1'b1, 32'h0000_0000};
    stall_exp[2] = {1'b1, 32'h0000_00FF};
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall valid %0d", i), ov0, 1'b1);
      check($sformatf("stall in_ready %0d", i), ir0, 1'b0);
      check($sformatf("stall sum %0d", i), s0, stall_exp[0][31:0]);
      check($sformatf("stall cout %0d", i), co0, stall_exp[0][32]);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ov0) begin
        if (idx < 3) begin
          check($sformatf("drain sum %0d", idx), s0, stall_exp[idx][31:0]);
          check($sformatf("drain cout %0d", idx), co0, stall_exp[idx][32]);
        end else begin
          check("drain extra beat", ov0, 1'b0);
        end
        idx++;
      end
      @(posedge clk);
      #1;
    end
    check("drain beat count", idx, 3);

    // Reset with three beats in flight discards all of them.
    drive(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(32'h0000_0033, 32'h0000_0044, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst flush valid", ov0, 1'b0);
    check("rst flush sum", s0, 32'h0);
    check("rst flush cout", co0, 1'b0);
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov0) idx++;
    end
    check("rst no stale beats", idx, 0);

    // Random handshake traffic against the scoreboard on all three widths.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
    while (rd[0] < 10000 && cyc < 40000) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom % 2);
      sub       = 1'($urandom % 2);
      @(negedge clk);
      sb_step();
      @(posedge clk);
      #1;
      cyc++;
    end
    check("random beat count reached", rd[0] >= 10000, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sb_step();
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("dut%0d beats outstanding", i), wr[i] - rd[i], 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
